// File: rtl/rv_pkg.sv
// Shared types for the load/store unit: FSM states, byte-mask constants, bus request fields.
// Pure declarations, no logic.
package rv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_st_e;

    localparam logic [3:0] BE_B = 4'h1;
    localparam logic [3:0] BE_H = 4'h3;
    localparam logic [3:0] BE_W = 4'hF;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Byte lanes touched by a lane-0 mask placed at offset off; bits [7:4] are overflow.
    function automatic logic [7:0] lane_span(input logic [3:0] mask, input logic [1:0] off);
        return {4'b0000, mask} << off;
    endfunction

endpackage

// File: rtl/u_lsu_if.sv
// Single-outstanding req/gnt/rvalid data-memory bus.
// master = load/store unit, slave = memory.
interface u_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/u_lsu_align.sv
// Byte-lane steering: store shift, byte enables, load extract/zero-fill, misalign flag.
// Latency: combinational. Backpressure: none (no state).
// Overflowing lanes fall off the top of be/wdata and out of the bottom of rd.
module u_lsu_align
    import rv_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  mask,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd,
    output logic        misalign
);

    logic [7:0]  span;
    logic [31:0] keep;

    always_comb begin
        span     = lane_span(mask, off);
        be       = span[3:0];
        misalign = |span[7:4];
        wdata    = wd << {off, 3'b000};
        keep     = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        rd       = (rdata >> {off, 3'b000}) & keep;
    end

endmodule

// File: rtl/u_lsu.sv
// Load/store unit: runs one execute-stage memory request on the req/gnt/rvalid bus, returns a vld pulse.
// Latency: 4 cycles minimum (IDLE, REQ, WAIT, DONE); each gnt/rvalid wait cycle adds one; TMO_CYC bounds the bus phase.
// Backpressure: lsu_busy holds execute while a request is pending; LSU_MISALIGN_EXC_EN enables the misaligned-access error.
module u_lsu
    import rv_pkg::*;
#(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lsu_a,
    input  logic [3:0]  lsu_we,
    input  logic [31:0] lsu_wd,
    input  logic [3:0]  lsu_re,
    output logic        lsu_busy,
    output logic        lsu_vld,
    output logic [31:0] lsu_rd,
    output logic        lsu_err,
    u_lsu_if.master     dmem
);

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    lsu_st_e     st_q, st_d;
    dmem_req_t   bus_q;
    logic [1:0]  off_q;
    logic [3:0]  mask_q;
    logic [15:0] cnt_q;
    logic        req_q, vld_q, err_q;
    logic [31:0] rd_q;

    logic        req_present, is_store, tmo_hit, mis_err, cap;
    logic [3:0]  mask_in;
    logic        vld_d, err_d;
    logic [31:0] rd_d;

    logic [1:0]  al_off;
    logic [3:0]  al_mask, al_be;
    logic [31:0] al_wdata, al_rd;
    logic        al_misalign;

    assign req_present = (|lsu_we) | (|lsu_re);
    assign is_store    = |lsu_we;
    assign mask_in     = is_store ? lsu_we : lsu_re;
    assign tmo_hit     = (cnt_q == TMO_LAST);

    // One aligner serves both phases: live inputs while idle, captured request afterwards.
    assign al_off  = (st_q == IDLE) ? lsu_a[1:0] : off_q;
    assign al_mask = (st_q == IDLE) ? mask_in    : mask_q;

    u_lsu_align u_align (
        .off      (al_off),
        .mask     (al_mask),
        .wd       (lsu_wd),
        .rdata    (dmem.dmem_rdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .rd       (al_rd),
        .misalign (al_misalign)
    );

`ifdef LSU_MISALIGN_EXC_EN
    assign mis_err = al_misalign;
`else
    logic unused_misalign;
    assign unused_misalign = al_misalign;
    assign mis_err         = 1'b0;
`endif

    always_comb begin
        st_d  = st_q;
        cap   = 1'b0;
        vld_d = 1'b0;
        err_d = 1'b0;
        rd_d  = '0;
        unique case (st_q)
            IDLE: begin
                if (req_present) begin
                    cap = 1'b1;
                    if (mis_err) begin
                        st_d  = DONE;
                        vld_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        st_d = REQ;
                    end
                end
            end
            REQ: begin
                if (tmo_hit) begin
                    st_d  = DONE;
                    vld_d = 1'b1;
                    err_d = 1'b1;
                end else if (dmem.dmem_gnt) begin
                    st_d = WAIT;
                end
            end
            WAIT: begin
                if (tmo_hit) begin
                    st_d  = DONE;
                    vld_d = 1'b1;
                    err_d = 1'b1;
                end else if (dmem.dmem_rvalid) begin
                    st_d  = DONE;
                    vld_d = 1'b1;
                    rd_d  = bus_q.we ? 32'h0 : al_rd;
                end
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            bus_q  <= '0;
            off_q  <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
            req_q  <= 1'b0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= '0;
        end else begin
            st_q  <= st_d;
            req_q <= (st_d == REQ);
            vld_q <= vld_d;
            err_q <= err_d;
            rd_q  <= rd_d;
            if (cap) begin
                off_q       <= lsu_a[1:0];
                mask_q      <= mask_in;
                bus_q.we    <= is_store;
                bus_q.be    <= al_be;
                bus_q.addr  <= {lsu_a[31:2], 2'b00};
                bus_q.wdata <= al_wdata;
            end
            if (st_q == IDLE && st_d == REQ) begin
                cnt_q <= '0;
            end else if (st_q == REQ || st_q == WAIT) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign lsu_busy = (st_q == IDLE && req_present) || st_q == REQ || st_q == WAIT;
    assign lsu_vld  = vld_q;
    assign lsu_err  = err_q;
    assign lsu_rd   = rd_q;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = bus_q.we;
    assign dmem.dmem_be    = bus_q.be;
    assign dmem.dmem_addr  = bus_q.addr;
    assign dmem.dmem_wdata = bus_q.wdata;

endmodule

// File: tb/tb_u_lsu.sv
// Directed bench for u_lsu: store, loads, backpressure, timeout (second instance, TMO_CYC=8),
// misaligned access (both LSU_MISALIGN_EXC_EN builds) and reset in WAIT.
module tb_u_lsu;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] lsu_a, lsu_wd, lsu_rd;
    logic [3:0]  lsu_we, lsu_re;
    logic        lsu_busy, lsu_vld, lsu_err;
    u_lsu_if bus();

    logic [31:0] t_a, t_wd, t_rd;
    logic [3:0]  t_we, t_re;
    logic        t_busy, t_vld, t_err;
    u_lsu_if tbus();

    u_lsu dut (
        .clk(clk), .rst(rst),
        .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd), .lsu_re(lsu_re),
        .lsu_busy(lsu_busy), .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_err(lsu_err),
        .dmem(bus)
    );

    u_lsu #(.TMO_CYC(8)) dut_tmo (
        .clk(clk), .rst(rst),
        .lsu_a(t_a), .lsu_we(t_we), .lsu_wd(t_wd), .lsu_re(t_re),
        .lsu_busy(t_busy), .lsu_vld(t_vld), .lsu_rd(t_rd), .lsu_err(t_err),
        .dmem(tbus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        lsu_a = '0; lsu_we = '0; lsu_wd = '0; lsu_re = '0;
    endtask

    // Called in the first REQ cycle: gnt immediately, rvalid the next cycle; returns in DONE.
    task automatic bus_fast(input logic [31:0] rdata);
        bus.dmem_gnt = 1'b1;
        cyc();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        cyc();
        bus.dmem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        t_a = '0; t_we = '0; t_wd = '0; t_re = '0;
        tbus.dmem_gnt = 1'b0; tbus.dmem_rvalid = 1'b0; tbus.dmem_rdata = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_req",   bus.dmem_req,   0);
        chk("rst_we",    bus.dmem_we,    0);
        chk("rst_be",    bus.dmem_be,    0);
        chk("rst_addr",  bus.dmem_addr,  0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_vld",   lsu_vld,        0);
        chk("rst_rd",    lsu_rd,         0);
        chk("rst_err",   lsu_err,        0);
        chk("rst_busy",  lsu_busy,       0);
        rst = 1'b0;
        cyc();

        // Word store, minimum latency
        lsu_a = 32'h100; lsu_we = BE_W; lsu_wd = 32'hDEADBEEF;
        #1;
        chk("st_busy_c0", lsu_busy, 1);
        chk("st_req_c0",  bus.dmem_req, 0);
        cyc();
        chk("st_req_c1",  bus.dmem_req,   1);
        chk("st_we",      bus.dmem_we,    1);
        chk("st_be",      bus.dmem_be,    32'hF);
        chk("st_addr",    bus.dmem_addr,  32'h100);
        chk("st_wdata",   bus.dmem_wdata, 32'hDEADBEEF);
        chk("st_busy_c1", lsu_busy, 1);
        bus.dmem_gnt = 1'b1;
        cyc();
        bus.dmem_gnt = 1'b0;
        chk("st_req_c2",  bus.dmem_req, 0);
        chk("st_busy_c2", lsu_busy, 1);
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
        cyc();
        bus.dmem_rvalid = 1'b0;
        chk("st_vld_c3",  lsu_vld,  1);
        chk("st_err_c3",  lsu_err,  0);
        chk("st_rd_c3",   lsu_rd,   0);
        chk("st_busy_c3", lsu_busy, 0);
        cyc();
        clear_in();
        #1;
        chk("st_vld_c4", lsu_vld, 0);
        chk("st_req_c4", bus.dmem_req, 0);

        // Byte load at lane 3
        lsu_a = 32'h203; lsu_re = BE_B;
        #1;
        chk("lb_busy", lsu_busy, 1);
        cyc();
        chk("lb_req",  bus.dmem_req,  1);
        chk("lb_we",   bus.dmem_we,   0);
        chk("lb_be",   bus.dmem_be,   32'h8);
        chk("lb_addr", bus.dmem_addr, 32'h200);
        bus_fast(32'hAABBCCDD);
        chk("lb_vld", lsu_vld, 1);
        chk("lb_rd",  lsu_rd,  32'h000000AA);
        chk("lb_err", lsu_err, 0);
        cyc();
        clear_in();

        // Both masks set: store wins
        lsu_a = 32'h101; lsu_we = BE_B; lsu_re = BE_W; lsu_wd = 32'h000000A5;
        cyc();
        chk("sb_we",    bus.dmem_we,    1);
        chk("sb_be",    bus.dmem_be,    32'h2);
        chk("sb_wdata", bus.dmem_wdata, 32'h0000A500);
        bus_fast(32'hFFFFFFFF);
        chk("sb_vld", lsu_vld, 1);
        chk("sb_rd",  lsu_rd,  0);
        cyc();
        clear_in();

        // Half load with gnt held off 5 cycles and rvalid 3 more
        lsu_a = 32'h102; lsu_re = BE_H;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_hold", bus.dmem_req, 1);
            chk("bp_be_hold",  bus.dmem_be,  32'hC);
            cyc();
        end
        chk("bp_req_gnt", bus.dmem_req, 1);
        bus.dmem_gnt = 1'b1;
        cyc();
        bus.dmem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wait_req",  bus.dmem_req, 0);
            chk("bp_wait_vld",  lsu_vld,      0);
            chk("bp_wait_busy", lsu_busy,     1);
            cyc();
        end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h11223344;
        cyc();
        bus.dmem_rvalid = 1'b0;
        chk("bp_vld", lsu_vld, 1);
        chk("bp_rd",  lsu_rd,  32'h00001122);
        chk("bp_err", lsu_err, 0);
        chk("bp_req_done", bus.dmem_req, 0);
        cyc();
        clear_in();
        #1;
        chk("bp_vld_after", lsu_vld, 0);
        chk("bp_no_dup_req", bus.dmem_req, 0);
        cyc();
        chk("bp_no_dup_req2", bus.dmem_req, 0);

        // Stray rvalid while idle
        bus.dmem_rvalid = 1'b1;
        cyc();
        bus.dmem_rvalid = 1'b0;
        chk("idle_rv_vld", lsu_vld, 0);
        cyc();
        chk("idle_rv_vld2", lsu_vld, 0);

        // Misaligned word store at a=0x102
        lsu_a = 32'h102; lsu_we = BE_W; lsu_wd = 32'h11223344;
        #1;
        chk("mis_busy", lsu_busy, 1);
        cyc();
`ifdef LSU_MISALIGN_EXC_EN
        chk("mis_req", bus.dmem_req, 0);
        chk("mis_vld", lsu_vld, 1);
        chk("mis_err", lsu_err, 1);
        chk("mis_rd",  lsu_rd,  0);
        cyc();
        clear_in();
        #1;
        chk("mis_vld_after", lsu_vld, 0);
        chk("mis_req_after", bus.dmem_req, 0);
`else
        chk("mis_req",   bus.dmem_req,   1);
        chk("mis_be",    bus.dmem_be,    32'hC);
        chk("mis_wdata", bus.dmem_wdata, 32'h33440000);
        bus_fast(32'h0);
        chk("mis_vld", lsu_vld, 1);
        chk("mis_err", lsu_err, 0);
        cyc();
        clear_in();
`endif

        // Reset while in WAIT
        cyc();
        lsu_a = 32'h300; lsu_re = BE_W;
        cyc();
        bus.dmem_gnt = 1'b1;
        cyc();
        bus.dmem_gnt = 1'b0;
        chk("rw_busy_wait", lsu_busy, 1);
        chk("rw_addr_pre",  bus.dmem_addr, 32'h300);
        rst = 1'b1;
        clear_in();
        #1;
        chk("rw_req",  bus.dmem_req,  0);
        chk("rw_be",   bus.dmem_be,   0);
        chk("rw_addr", bus.dmem_addr, 0);
        chk("rw_busy", lsu_busy,      0);
        chk("rw_vld",  lsu_vld,       0);
        cyc();
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
        cyc();
        bus.dmem_rvalid = 1'b0;
        chk("rw_late_vld", lsu_vld, 0);
        cyc();
        chk("rw_late_vld2", lsu_vld, 0);
        chk("rw_late_rd",   lsu_rd,  0);

        // Timeout on the TMO_CYC=8 instance, gnt never asserted
        t_a = 32'h40; t_re = BE_W;
        cyc();
        n_req = 0;
        for (int i = 0; i < 20 && tbus.dmem_req; i++) begin
            n_req++;
            cyc();
        end
        chk("tmo_req_cycles", n_req, 8);
        chk("tmo_req_drop", tbus.dmem_req, 0);
        chk("tmo_vld",  t_vld,  1);
        chk("tmo_err",  t_err,  1);
        chk("tmo_rd",   t_rd,   0);
        chk("tmo_busy", t_busy, 0);
        cyc();
        t_re = '0;
        #1;
        chk("tmo_vld_after", t_vld, 0);
        t_re = BE_B;
        #1;
        chk("tmo_idle_busy", t_busy, 1);
        chk("tmo_idle_req",  tbus.dmem_req, 0);
        t_re = '0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/u_lsu.md
# u_lsu

Load/store unit sitting directly downstream of the execute stage. It takes the registered memory request the execute stage presents (byte address, write/read byte masks, write data) and runs it on a single-outstanding req/gnt/rvalid data-memory bus. It returns a one-cycle completion pulse with lane-aligned load data, and raises a busy signal that the hazard unit turns into `stall1`.

## Interface
Parameters:
- `TMO_CYC`, default 255: bus timeout in cycles, counted from entry into REQ. Legal range 1..65535.

Ports:
- `clk`  in  1  the one clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `lsu_a`  in  32  byte address from execute
- `lsu_we`  in  4  store byte mask, lane-0 aligned (1, 3 or F)
- `lsu_wd`  in  32  store data, lane-0 aligned
- `lsu_re`  in  4  load byte mask, lane-0 aligned
- `lsu_busy`  out  1  request held; execute must not update the `lsu_*` inputs
- `lsu_vld`  out  1  one-cycle completion pulse
- `lsu_rd`  out  32  load data, right-aligned and zero-filled above the mask
- `lsu_err`  out  1  qualifies `lsu_vld`: timeout or misaligned access
- `dmem_req`  out  1  bus request
- `dmem_we`  out  1  1 = write
- `dmem_be`  out  4  shifted byte enables
- `dmem_addr`  out  32  word address: `{lsu_a[31:2],2'b00}`
- `dmem_wdata`  out  32  `lsu_wd << (8*a[1:0])`
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  response; legal no earlier than the cycle after `dmem_gnt`
- `dmem_rdata`  in  32  read data, valid with `dmem_rvalid`

## Operation
- A request is present when `|lsu_we | |lsu_re`. If both masks are nonzero, the access is a store and `lsu_re` is ignored.
- FSM states are IDLE, REQ, WAIT and DONE.
- IDLE with a request present: capture address, mask, data and direction into internal registers, then go to REQ (or to DONE on a misaligned error; see Configuration).
- REQ: `dmem_req=1` with stable bus fields. When `dmem_gnt=1`, go to WAIT.
- WAIT: when `dmem_rvalid=1`, latch data and go to DONE. An `rvalid` seen in IDLE, REQ or DONE is ignored.
- DONE: `lsu_vld=1` for one cycle, then return to IDLE unconditionally. Inputs are never sampled in DONE, because execute still shows the old request there.
- `lsu_busy = (IDLE & request present) | REQ | WAIT`. It is combinational from the registered inputs and is 0 in DONE, which lets execute load the next request at the edge that ends DONE.
- Lane logic:
  - `dmem_be = (mask << a[1:0])[3:0]`
  - Load result is `(dmem_rdata >> 8*a[1:0])` with the bytes outside the unshifted mask forced to 0.
  - Sign extension is not this block's job.
- Timeout:
  - A 16-bit counter clears on entering REQ and increments in REQ and WAIT.
  - At `TMO_CYC`, go to DONE with `lsu_err=1` and `lsu_rd=0`. `dmem_req` drops the same cycle.
- A store completes with `lsu_rd=0`.

## Timing
- Reset values:
  - State is IDLE.
  - `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `lsu_vld`, `lsu_rd`, `lsu_err` and the counter are all 0.
  - `lsu_busy` follows its equation.
- Reset mid-transaction aborts at once: `dmem_req` drops asynchronously and the request is lost. Upstream is flushed by the same reset.
- Minimum latency is 4 cycles, with request seen in cycle 0: IDLE (c0), REQ with `gnt` (c1), WAIT with `rvalid` (c2), DONE with `lsu_vld` (c3).
- Each extra `gnt`/`rvalid` wait cycle adds one cycle.
- Throughput is at most one access per 4 cycles.
- All outputs except `lsu_busy` are registered.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - An access where `mask << a[1:0]` carries bits beyond lane 3 is misaligned. Examples: word with `a[1:0]≠0`, half with `a[1:0]=3`.
  - A misaligned access goes IDLE→DONE with no bus request, `lsu_err=1`, `lsu_rd=0`.
- Undefined: no misalign check. Overflowing lanes are dropped from `dmem_be` and `lsu_rd`, and `lsu_err` can only come from a timeout.

## Structure
- Package `rv_pkg` holds:
  - `lsu_st_e` (IDLE/REQ/WAIT/DONE)
  - mask constants `BE_B=4'h1`, `BE_H=4'h3`, `BE_W=4'hF`
  - struct `dmem_req_t` {we, be, addr, wdata}
- Sub-module `u_lsu_align` is purely combinational: store shift and `be` generation, load extract and mask, misalign flag.
- The FSM, capture registers and timeout counter stay in `u_lsu`.

## Test plan
- Store: `lsu_a=0x100`, `lsu_we=F`, `lsu_wd=0xDEADBEEF`, `gnt` and `rvalid` each one cycle later -> `dmem_be=F`, `dmem_wdata=0xDEADBEEF`; `lsu_vld` in cycle 3 with `lsu_err=0`; `lsu_busy` 1 in cycles 0–2.
- Byte load: `lsu_a=0x203`, `lsu_re=1`, `rdata=0xAABBCCDD` -> `dmem_be=8`, `dmem_addr=0x200`, `lsu_rd=0x000000AA`.
- Backpressure: `gnt` delayed 5 cycles, `rvalid` 3 more -> `dmem_req` stable throughout; one `lsu_vld`; no duplicate request in DONE.
- Timeout with `TMO_CYC=8`, `gnt` never asserted -> `dmem_req` drops after 8 cycles; `lsu_vld=1`, `lsu_err=1`, `lsu_rd=0`; FSM returns to IDLE.
- Misaligned word at `a=0x102`: with `LSU_MISALIGN_EXC_EN` -> no `dmem_req`, `lsu_err=1`. Without it -> `dmem_be=C`, `lsu_err=0`.
- `rst` pulsed while in WAIT -> all outputs 0 immediately; a later `rvalid` produces no `lsu_vld`.
